rm_seq_lane_tracker: RTL and testbench

- Parametrised successor to the fixed-chain runtime-monitor lane allocation / event-shift scheme.
- Tracks up to NUM_LANES concurrently monitored instructions. Each lane walks an ordered chain of NUM_EVENTS event detectors.
- Adds a per-lane watchdog timeout, an optional strict-order violation mode, a valid/ready allocation handshake and per-lane progress visibility.
- Sits between the event detectors (lane_ctrl producers) and rm_monitor, replacing the hard-wired rm_cnt shift chain.

---
 rtl/rm_seq_lane_tracker_if.sv | 23 ++
 rtl/rm_seq_lane_tracker.sv | 184 ++++++++++++++++++
 tb/tb_rm_seq_lane_tracker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rm_seq_lane_tracker_if.sv
// Allocation handshake between the issue side and the lane tracker.
// The tracker owns ready and the granted lane index.
interface rm_seq_lane_tracker_if #(
    parameter int VLEN      = 64,
    parameter int NUM_LANES = 7
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic            alloc_valid_i;
    logic            alloc_ready_o;
    logic [VLEN-1:0] alloc_pc_i;
    logic [LW-1:0]   alloc_lane_o;

    modport master (
        output alloc_valid_i, alloc_pc_i,
        input  alloc_ready_o, alloc_lane_o
    );

    modport slave (
        input  alloc_valid_i, alloc_pc_i,
        output alloc_ready_o, alloc_lane_o
    );
endinterface

// File: rtl/rm_seq_lane_tracker.sv
// Runtime-monitor lane tracker: allocates monitored instructions to lanes and
// walks each lane through an ordered event chain with watchdog and order checks.

module rm_seq_lane #(
    parameter int NUM_EVENTS   = 6,
    parameter int TIMEOUT      = 16,
    parameter bit STRICT_ORDER = 1'b1,
    parameter int VLEN         = 64,
    parameter int SW           = 3,
    parameter int TW           = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  grant_i,
    input  logic [VLEN-1:0]       pc_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  reset_i,
    output logic                  busy_o,
    output logic [SW-1:0]         stage_o,
    output logic [VLEN-1:0]       pc_o,
    output logic                  done_o,
    output logic                  violation_o,
    output logic                  timeout_o
);
    logic            busy_q, busy_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [VLEN-1:0] pc_q, pc_d;
    logic            done_q, done_d;
    logic            viol_q, viol_d;
    logic            tmo_q, tmo_d;
    logic [NUM_EVENTS-1:0] later;
    logic            hit, last, expired;

    always_comb begin
        later = '0;
        for (int j = 0; j < NUM_EVENTS; j++) later[j] = (j > int'(stage_q));
    end

    assign hit     = event_i[stage_q];
    assign last    = (stage_q == SW'(NUM_EVENTS - 1));
    assign expired = (TIMEOUT > 0) && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        busy_d  = busy_q;
        stage_d = stage_q;
        timer_d = timer_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        viol_d  = 1'b0;
        tmo_d   = 1'b0;
        if (grant_i) begin
            // grant only targets free lanes, so it never races a busy-lane action
            busy_d  = 1'b1;
            stage_d = '0;
            timer_d = '0;
            pc_d    = pc_i;
        end else if (busy_q) begin
            if (reset_i) begin
                busy_d  = 1'b0;
                timer_d = '0;
            end else if (hit && last) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                timer_d = '0;
            end else if (hit) begin
                stage_d = stage_q + SW'(1);
                timer_d = '0;
            end else if (STRICT_ORDER && |(event_i & later)) begin
                viol_d  = 1'b1;
                busy_d  = 1'b0;
                timer_d = '0;
            end else if (expired) begin
                tmo_d   = 1'b1;
                busy_d  = 1'b0;
                timer_d = '0;
            end else if (timer_q != '1) begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            stage_q <= '0;
            timer_q <= '0;
            pc_q    <= '0;
            done_q  <= 1'b0;
            viol_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            stage_q <= stage_d;
            timer_q <= timer_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            viol_q  <= viol_d;
            tmo_q   <= tmo_d;
        end
    end

    assign busy_o      = busy_q;
    assign stage_o     = stage_q;
    assign pc_o        = pc_q;
    assign done_o      = done_q;
    assign violation_o = viol_q;
    assign timeout_o   = tmo_q;
endmodule

module rm_seq_lane_tracker #(
    parameter int NUM_LANES    = 7,
    parameter int NUM_EVENTS   = 6,
    parameter int TIMEOUT      = 16,
    parameter bit STRICT_ORDER = 1'b1,
    parameter int VLEN         = 64,
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int SW = $clog2(NUM_EVENTS),
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    rm_seq_lane_tracker_if.slave                alloc_if,
    input  logic [NUM_EVENTS-1:0]               event_i,
    input  logic [NUM_LANES-1:0]                lane_reset_i,
    output logic [NUM_LANES-1:0]                lane_busy_o,
    output logic [NUM_LANES-1:0][SW-1:0]        lane_stage_o,
    output logic [NUM_LANES-1:0][VLEN-1:0]      lane_pc_o,
    output logic [NUM_LANES-1:0]                done_o,
    output logic [NUM_LANES-1:0]                violation_o,
    output logic [NUM_LANES-1:0]                timeout_o
);
    logic                 alloc_en_q;
    logic [NUM_LANES-1:0] free, grant;
    logic [LW-1:0]        grant_idx;
    logic                 ready;

    // keeps ready low while reset is held, even though every lane reads free
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) alloc_en_q <= 1'b0;
        else         alloc_en_q <= 1'b1;
    end

    assign free  = ~lane_busy_o;
    assign ready = alloc_en_q & (|free);

    always_comb begin
        grant_idx = '0;
        for (int l = NUM_LANES - 1; l >= 0; l--)
            if (free[l]) grant_idx = LW'(l);
    end

    always_comb begin
        grant = '0;
        if (alloc_if.alloc_valid_i && ready) grant[grant_idx] = 1'b1;
    end

    assign alloc_if.alloc_ready_o = ready;
    assign alloc_if.alloc_lane_o  = grant_idx;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        rm_seq_lane #(
            .NUM_EVENTS  (NUM_EVENTS),
            .TIMEOUT     (TIMEOUT),
            .STRICT_ORDER(STRICT_ORDER),
            .VLEN        (VLEN),
            .SW          (SW),
            .TW          (TW)
        ) u_lane (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .grant_i    (grant[l]),
            .pc_i       (alloc_if.alloc_pc_i),
            .event_i    (event_i),
            .reset_i    (lane_reset_i[l]),
            .busy_o     (lane_busy_o[l]),
            .stage_o    (lane_stage_o[l]),
            .pc_o       (lane_pc_o[l]),
            .done_o     (done_o[l]),
            .violation_o(violation_o[l]),
            .timeout_o  (timeout_o[l])
        );
    end
endmodule

// File: tb/tb_rm_seq_lane_tracker.sv
// Directed bench: strict-order tracker (a) plus a relaxed-order twin (b).
module tb_rm_seq_lane_tracker;
    localparam int NL = 7, NE = 6, VL = 64;

    logic clk = 1'b0, rst_n = 1'b1;
    always #5 clk = ~clk;

    rm_seq_lane_tracker_if #(.VLEN(VL), .NUM_LANES(NL)) ifa ();
    rm_seq_lane_tracker_if #(.VLEN(VL), .NUM_LANES(NL)) ifb ();

    logic [NE-1:0]         ev_a, ev_b;
    logic [NL-1:0]         lr_a, lr_b;
    logic [NL-1:0]         busy_a, busy_b, done_a, done_b, viol_a, viol_b, tmo_a, tmo_b;
    logic [NL-1:0][2:0]    stg_a, stg_b;
    logic [NL-1:0][VL-1:0] pc_a, pc_b;

    rm_seq_lane_tracker #(.STRICT_ORDER(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .alloc_if(ifa.slave), .event_i(ev_a),
        .lane_reset_i(lr_a), .lane_busy_o(busy_a), .lane_stage_o(stg_a),
        .lane_pc_o(pc_a), .done_o(done_a), .violation_o(viol_a), .timeout_o(tmo_a)
    );
    rm_seq_lane_tracker #(.STRICT_ORDER(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .alloc_if(ifb.slave), .event_i(ev_b),
        .lane_reset_i(lr_b), .lane_busy_o(busy_b), .lane_stage_o(stg_b),
        .lane_pc_o(pc_b), .done_o(done_b), .violation_o(viol_b), .timeout_o(tmo_b)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.alloc_valid_i = 0; ifa.alloc_pc_i = '0;
        ifb.alloc_valid_i = 0; ifb.alloc_pc_i = '0;
        ev_a = '0; ev_b = '0; lr_a = '0; lr_b = '0;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_ready", 64'(ifa.alloc_ready_o), 0);
        chk("rst_lane", 64'(ifa.alloc_lane_o), 0);
        chk("rst_stage", 64'(stg_a), 0);
        chk("rst_pulses", 64'({done_a, viol_a, tmo_a}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 64'(ifa.alloc_ready_o), 1);

        // full chain on lane 0
        ifa.alloc_valid_i = 1; ifa.alloc_pc_i = 64'h8000_0000;
        chk("chain_grant_lane", 64'(ifa.alloc_lane_o), 0);
        tick();
        ifa.alloc_valid_i = 0;
        chk("chain_busy", 64'(busy_a), 64'h1);
        chk("chain_pc", pc_a[0], 64'h8000_0000);
        chk("chain_stage0", 64'(stg_a[0]), 0);
        for (int k = 0; k < NE; k++) begin
            ev_a = NE'(1) << k;
            tick();
            if (k < NE - 1) chk("chain_stage", 64'(stg_a[0]), 64'(k + 1));
            else begin
                chk("chain_done", 64'(done_a), 64'h1);
                chk("chain_freed", 64'(busy_a), 0);
            end
        end
        ev_a = '0;
        tick();
        chk("chain_done_1cyc", 64'(done_a), 0);
        chk("chain_stage_hold", 64'(stg_a[0]), 5);

        // fill all lanes, offer while full, free lane 3, regrant
        ifa.alloc_valid_i = 1;
        for (int i = 0; i < NL; i++) begin
            ifa.alloc_pc_i = 64'h1000 + 64'(i);
            chk("fill_lane", 64'(ifa.alloc_lane_o), 64'(i));
            tick();
        end
        chk("full_busy", 64'(busy_a), 64'h7f);
        chk("full_ready", 64'(ifa.alloc_ready_o), 0);
        ifa.alloc_pc_i = 64'hdead;
        tick();
        chk("full_ignored_busy", 64'(busy_a), 64'h7f);
        chk("full_ignored_pc6", pc_a[6], 64'h1006);
        lr_a = 7'h08;
        chk("free_cycle_ready", 64'(ifa.alloc_ready_o), 0);
        tick();
        lr_a = '0;
        chk("freed_busy", 64'(busy_a), 64'h77);
        chk("freed_ready", 64'(ifa.alloc_ready_o), 1);
        chk("regrant_lane", 64'(ifa.alloc_lane_o), 3);
        tick();
        ifa.alloc_valid_i = 0;
        chk("regrant_busy", 64'(busy_a), 64'h7f);
        chk("regrant_pc", pc_a[3], 64'hdead);
        lr_a = '1;
        tick();
        lr_a = '0;
        chk("flush_busy", 64'(busy_a), 0);
        chk("flush_no_pulse", 64'({done_a, viol_a, tmo_a}), 0);

        // watchdog without events
        ifa.alloc_valid_i = 1;
        tick();
        ifa.alloc_valid_i = 0;
        repeat (15) tick();
        chk("tmo_not_yet", 64'({busy_a[0], tmo_a[0]}), 64'b10);
        tick();
        chk("tmo_pulse", 64'(tmo_a), 64'h1);
        chk("tmo_freed", 64'(busy_a), 0);
        tick();
        chk("tmo_1cyc", 64'(tmo_a), 0);

        // watchdog restarted by an advance 10 cycles in
        ifa.alloc_valid_i = 1;
        tick();
        ifa.alloc_valid_i = 0;
        repeat (9) tick();
        ev_a = 6'b000001;
        tick();
        ev_a = '0;
        chk("tmo2_stage", 64'(stg_a[0]), 1);
        repeat (15) tick();
        chk("tmo2_not_yet", 64'({busy_a[0], tmo_a[0]}), 64'b10);
        tick();
        chk("tmo2_pulse", 64'(tmo_a), 64'h1);

        // strict vs relaxed ordering
        ifa.alloc_valid_i = 1; ifb.alloc_valid_i = 1; ifb.alloc_pc_i = 64'h44;
        tick();
        ifa.alloc_valid_i = 0; ifb.alloc_valid_i = 0;
        ev_a = 6'b000001; ev_b = 6'b000001;
        tick();
        chk("ord_stage1", 64'({stg_a[0], stg_b[0]}), 64'o11);
        tick();
        chk("ord_earlier_ignored", 64'({busy_a[0], viol_a[0], stg_a[0]}), 64'b1_0_001);
        ev_a = 6'b000100; ev_b = 6'b000100;
        tick();
        ev_a = '0; ev_b = '0;
        chk("strict_viol", 64'(viol_a), 64'h1);
        chk("strict_freed", 64'({busy_a[0], stg_a[0]}), 64'b0_001);
        chk("relaxed_no_viol", 64'({busy_b[0], viol_b[0], stg_b[0]}), 64'b1_0_001);
        tick();
        chk("viol_1cyc", 64'(viol_a), 0);
        lr_b = '1;
        tick();
        lr_b = '0;

        // done beats timer expiry in the same cycle
        ifa.alloc_valid_i = 1;
        tick();
        ifa.alloc_valid_i = 0;
        for (int k = 0; k < NE - 1; k++) begin ev_a = NE'(1) << k; tick(); end
        ev_a = '0;
        chk("prio_stage5", 64'(stg_a[0]), 5);
        repeat (15) tick();
        ev_a = 6'b100000;
        tick();
        ev_a = '0;
        chk("prio_done_only", 64'({done_a[0], tmo_a[0], busy_a[0]}), 64'b100);

        // lane reset beats both
        ifa.alloc_valid_i = 1;
        tick();
        ifa.alloc_valid_i = 0;
        for (int k = 0; k < NE - 1; k++) begin ev_a = NE'(1) << k; tick(); end
        ev_a = '0;
        repeat (15) tick();
        ev_a = 6'b100000; lr_a = 7'h01;
        tick();
        ev_a = '0; lr_a = '0;
        chk("lreset_no_pulse", 64'({done_a[0], tmo_a[0], busy_a[0]}), 0);

        // asynchronous reset mid-chain
        ifa.alloc_valid_i = 1;
        repeat (4) tick();
        ifa.alloc_valid_i = 0;
        ev_a = 6'b000001;
        tick();
        ev_a = '0;
        chk("mid_busy4", 64'(busy_a), 64'h0f);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_a), 0);
        chk("arst_stage", 64'(stg_a), 0);
        chk("arst_pc", 64'(|pc_a), 0);
        chk("arst_ready", 64'(ifa.alloc_ready_o), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        ifa.alloc_valid_i = 1; ifa.alloc_pc_i = 64'h77;
        chk("post_rst_lane", 64'({ifa.alloc_ready_o, ifa.alloc_lane_o}), 64'b1_000);
        tick();
        ifa.alloc_valid_i = 0;
        chk("post_rst_busy", 64'(busy_a), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
